// File: rtl/wdt_reset_ctrl.sv
// rtl/wdt_reset_ctrl.sv - watchdog overflow to warn/grace/reset-pulse sequencer with reset-event counter
module wdt_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned GRACE_WIDTH      = 16,
  parameter int unsigned CNT_WIDTH        = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ovf_i,
  input  logic [GRACE_WIDTH-1:0] grace_i,
  input  logic                   ack_i,
  input  logic                   clr_count_i,
  output logic                   irq_o,
  output logic                   wdt_rst_o,
  output logic [1:0]             state_o,
  output logic [CNT_WIDTH-1:0]   rst_count_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WARN    = 2'd1;
  localparam logic [1:0] ST_RESET   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  localparam logic [15:0]            PULSE_LOAD = 16'(RST_PULSE_CYCLES);
  localparam logic [15:0]            PULSE_ONE  = 16'd1;
  localparam logic [GRACE_WIDTH-1:0] GRACE_ONE  = GRACE_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;

  logic [1:0]             state_q, state_d;
  logic [GRACE_WIDTH-1:0] grace_q, grace_d;
  logic [15:0]            pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   ovf_q;
  logic                   rise;
  logic                   enter_reset;

  // ovf_q starts at 0, so an overflow already high out of reset is taken as a rise
  assign rise = ovf_i & ~ovf_q;

  // Sequencer next-state: warn window, reset pulse, then hold off until overflow clears
  always_comb begin
    state_d     = state_q;
    grace_d     = grace_q;
    pulse_d     = pulse_q;
    enter_reset = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (grace_i != '0) begin
            state_d = ST_WARN;
            grace_d = grace_i;
          end else begin
            enter_reset = 1'b1;
          end
        end
      end
      ST_WARN: begin
        if (ack_i) begin
          state_d = ST_IDLE;
        end else if (grace_q == GRACE_ONE) begin
          enter_reset = 1'b1;
        end else begin
          grace_d = grace_q - GRACE_ONE;
        end
      end
      ST_RESET: begin
        if (pulse_q == PULSE_ONE) begin
          state_d = ST_HOLDOFF;
        end else begin
          pulse_d = pulse_q - PULSE_ONE;
        end
      end
      default: begin
        if (!ovf_i) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    if (enter_reset) begin
      state_d = ST_RESET;
      pulse_d = PULSE_LOAD;
    end
  end

  // Reset-event counter: a clear in the same cycle as an entry still counts that entry
  always_comb begin
    count_d = count_q;
    if (enter_reset) begin
      if (clr_count_i) begin
        count_d = CNT_ONE;
      end else if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end
    end else if (clr_count_i) begin
      count_d = '0;
    end
  end

  // State and counter registers; async reset clears everything including the event count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grace_q <= '0;
      pulse_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      ovf_q   <= ovf_i;
    end
  end

  assign irq_o       = (state_q == ST_WARN);
  assign wdt_rst_o   = (state_q == ST_RESET);
  assign state_o     = state_q;
  assign rst_count_o = count_q;

endmodule
